// File: rtl/multiplier_if.sv
// Operand/strobe/result bundle for the sequential shift-add multiplier.
//   master : drives operands and phase strobes, observes the result
//   slave  : the multiplier itself
// Signals:
//   data_in_a, data_in_b : unsigned operands (WORD_LENGTH bits each)
//   Start, FinishLoad, FinishShift, Finish : phase strobes, level sampled
//   Reset_Sync           : synchronous abort/clear back to idle
//   data_out             : registered product (2*WORD_LENGTH bits)
//   ready                : result valid
//   cout                 : carry out of the final add step
interface multiplier_if #(
    parameter int WORD_LENGTH = 4
) ();
    logic [WORD_LENGTH-1:0]   data_in_a;
    logic [WORD_LENGTH-1:0]   data_in_b;
    logic                     Start;
    logic                     FinishLoad;
    logic                     FinishShift;
    logic                     Finish;
    logic                     Reset_Sync;
    logic [2*WORD_LENGTH-1:0] data_out;
    logic                     ready;
    logic                     cout;

    modport master (
        output data_in_a, data_in_b, Start, FinishLoad, FinishShift, Finish, Reset_Sync,
        input  data_out, ready, cout
    );

    modport slave (
        input  data_in_a, data_in_b, Start, FinishLoad, FinishShift, Finish, Reset_Sync,
        output data_out, ready, cout
    );
endinterface

// File: rtl/multiplier.sv
// Sequential unsigned shift-add multiplier, one partial-product step per cycle.
// Phases are advanced by external level strobes: Start (idle -> load, operands
// captured), FinishLoad (load -> shift), FinishShift (shift -> finish, only
// after all WORD_LENGTH steps), Finish (finish -> done, result published).
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, highest priority
//   bus   : multiplier_if slave (operands, strobes, Reset_Sync, data_out,
//           ready, cout)
module multiplier #(
    parameter int WORD_LENGTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    multiplier_if.slave  bus
);
    localparam int N    = WORD_LENGTH;
    localparam int CntW = $clog2(N + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StFinish,
        StDone
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    q_q, q_d;
    logic [N-1:0]    acc_q, acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            c_q, c_d;
    logic [2*N-1:0]  data_out_q, data_out_d;
    logic            cout_q, cout_d;

    // Step datapath
    logic [N:0]      sum;
    logic            step_c;
    logic [N-1:0]    step_acc;
    logic [N:0]      acc_ext;
    logic [N:0]      q_ext;
    logic            steps_done;

    assign sum        = {1'b0, acc_q} + {1'b0, a_q};
    assign step_c     = q_q[0] ? sum[N] : 1'b0;
    assign step_acc   = q_q[0] ? sum[N-1:0] : acc_q;
    // {c, ACC, Q} >> 1, split into its two halves so that N = 1 stays legal.
    assign acc_ext    = {step_c, step_acc};
    assign q_ext      = {acc_ext[0], q_q};
    assign steps_done = (cnt_q == CntW'(N));

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        q_d        = q_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        c_d        = c_q;
        data_out_d = data_out_q;
        cout_d     = cout_q;

        if (bus.Reset_Sync) begin
            state_d    = StIdle;
            a_d        = '0;
            q_d        = '0;
            acc_d      = '0;
            cnt_d      = '0;
            c_d        = 1'b0;
            data_out_d = '0;
            cout_d     = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.Start) begin
                        state_d = StLoad;
                        a_d     = bus.data_in_a;
                        q_d     = bus.data_in_b;
                        acc_d   = '0;
                        cnt_d   = '0;
                        c_d     = 1'b0;
                    end
                end
                StLoad: begin
                    if (bus.FinishLoad) begin
                        state_d = StShift;
                    end
                end
                StShift: begin
                    if (!steps_done) begin
                        acc_d = acc_ext[N:1];
                        q_d   = q_ext[N:1];
                        // Keep the add carry itself: it is the MSB shifted into ACC
                        // and also what cout reports.
                        c_d   = step_c;
                        cnt_d = cnt_q + CntW'(1);
                    end else if (bus.FinishShift) begin
                        state_d = StFinish;
                    end
                end
                StFinish: begin
                    if (bus.Finish) begin
                        state_d    = StDone;
                        data_out_d = {acc_q, q_q};
                        cout_d     = c_q;
                    end
                end
                StDone: begin
                    // Hold the result until Reset_Sync or reset.
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            a_q        <= '0;
            q_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            c_q        <= 1'b0;
            data_out_q <= '0;
            cout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            q_q        <= q_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            c_q        <= c_d;
            data_out_q <= data_out_d;
            cout_q     <= cout_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.cout     = cout_q;
    assign bus.ready    = (state_q == StDone);

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for the sequential multiplier: directed cases plus
// randomized operands and phase timing, checked against an arithmetic model.
module tb_multiplier;
    localparam int N = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    multiplier_if #(.WORD_LENGTH(N)) mif ();

    multiplier #(.WORD_LENGTH(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Product is a*b; the carry of the last step exists only when the top bit
    // of b adds a onto the partial product of the lower N-1 bits, scaled down.
    task automatic model(input int unsigned a, input int unsigned b,
                         output int unsigned prod, output int unsigned carry);
        int unsigned low;
        int unsigned acc_prev;
        prod     = a * b;
        low      = b % (1 << (N - 1));
        acc_prev = (a * low) >> (N - 1);
        if (((b >> (N - 1)) & 1) == 1)
            carry = ((acc_prev + a) >= (1 << N)) ? 1 : 0;
        else
            carry = 0;
    endtask

    task automatic idle_inputs();
        mif.Start       = 1'b0;
        mif.FinishLoad  = 1'b0;
        mif.FinishShift = 1'b0;
        mif.Finish      = 1'b0;
        mif.Reset_Sync  = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_data_out"}, 32'(mif.data_out), 0);
        check({tag, "_ready"}, 32'(mif.ready), 0);
        check({tag, "_cout"}, 32'(mif.cout), 0);
    endtask

    task automatic clear_sync();
        mif.Reset_Sync = 1'b1;
        tick();
        mif.Reset_Sync = 1'b0;
        check_cleared("rsync");
    endtask

    // Full operation; lw = extra cycles spent in LOAD, scramble = wiggle the
    // operand inputs while busy (they must be ignored).
    task automatic run_op(input int unsigned a, input int unsigned b, input int lw,
                          input bit scramble);
        int unsigned exp_p;
        int unsigned exp_c;
        int          cycles;
        logic [2*N-1:0] held;
        model(a, b, exp_p, exp_c);
        mif.data_in_a = N'(a);
        mif.data_in_b = N'(b);
        mif.Start     = 1'b1;
        tick();
        mif.Start = 1'b0;
        cycles    = 0;
        repeat (lw) begin
            if (scramble) begin
                mif.data_in_a = N'($urandom);
                mif.data_in_b = N'($urandom);
            end
            mif.Finish = scramble ? 1'($urandom) : 1'b0;
            tick();
            cycles++;
            check("load_ready", 32'(mif.ready), 0);
        end
        mif.Finish     = 1'b0;
        mif.FinishLoad = 1'b1;
        tick();
        cycles++;
        mif.FinishLoad  = 1'b0;
        mif.FinishShift = 1'b1;
        mif.Finish      = 1'b1;
        while (!mif.ready && cycles < 40) begin
            check("busy_data_out", 32'(mif.data_out), 0);
            if (scramble) begin
                mif.data_in_a = N'($urandom);
                mif.data_in_b = N'($urandom);
            end
            tick();
            cycles++;
        end
        mif.FinishShift = 1'b0;
        mif.Finish      = 1'b0;
        check("latency", 32'(cycles), 32'(lw + N + 3));
        check("ready", 32'(mif.ready), 1);
        check("product", 32'(mif.data_out), exp_p);
        check("cout", 32'(mif.cout), exp_c);
        // DONE must hold regardless of other strobes/operands.
        held = mif.data_out;
        repeat (3) begin
            mif.Start       = 1'($urandom);
            mif.FinishLoad  = 1'($urandom);
            mif.FinishShift = 1'($urandom);
            mif.Finish      = 1'($urandom);
            mif.data_in_a   = N'($urandom);
            mif.data_in_b   = N'($urandom);
            tick();
            check("hold_data_out", 32'(mif.data_out), 32'(held));
            check("hold_ready", 32'(mif.ready), 1);
        end
        idle_inputs();
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        mif.data_in_a = '0;
        mif.data_in_b = '0;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        check_cleared("reset");

        // Directed products
        run_op(7, 3, 0, 1'b0);
        clear_sync();
        run_op(15, 15, 0, 1'b0);
        clear_sync();
        run_op(0, 9, 0, 1'b0);
        clear_sync();
        run_op(9, 0, 1, 1'b0);
        clear_sync();

        // Early FinishShift is ignored, a stray Finish in SHIFT too
        mif.data_in_a = 4'd7;
        mif.data_in_b = 4'd3;
        mif.Start     = 1'b1;
        tick();
        mif.Start      = 1'b0;
        mif.FinishLoad = 1'b1;
        tick();
        mif.FinishLoad  = 1'b0;
        mif.FinishShift = 1'b1;
        tick();
        mif.FinishShift = 1'b0;
        repeat (6) tick();
        mif.Finish = 1'b1;
        tick();
        mif.Finish = 1'b0;
        check("early_fs_ready", 32'(mif.ready), 0);
        tick();
        check("early_fs_ready2", 32'(mif.ready), 0);
        mif.FinishShift = 1'b1;
        tick();
        mif.FinishShift = 1'b0;
        mif.Finish      = 1'b1;
        tick();
        mif.Finish = 1'b0;
        check("late_fs_ready", 32'(mif.ready), 1);
        check("late_fs_product", 32'(mif.data_out), 21);

        // Reset_Sync from DONE, then a fresh operation
        clear_sync();
        run_op(5, 6, 0, 1'b0);
        clear_sync();

        // reset in SHIFT aborts; Finish alone afterwards does nothing
        mif.data_in_a = 4'd15;
        mif.data_in_b = 4'd15;
        mif.Start     = 1'b1;
        tick();
        mif.Start      = 1'b0;
        mif.FinishLoad = 1'b1;
        tick();
        mif.FinishLoad = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_cleared("mid_reset");
        mif.Finish = 1'b1;
        tick();
        mif.Finish = 1'b0;
        check_cleared("post_reset_finish");
        mif.FinishShift = 1'b1;
        mif.Finish      = 1'b1;
        repeat (8) tick();
        idle_inputs();
        check_cleared("post_reset_strobes");

        // Reset_Sync mid-operation aborts as well
        mif.data_in_a = 4'd11;
        mif.data_in_b = 4'd13;
        mif.Start     = 1'b1;
        tick();
        mif.Start      = 1'b0;
        mif.FinishLoad = 1'b1;
        tick();
        mif.FinishLoad  = 1'b0;
        mif.FinishShift = 1'b1;
        mif.Finish      = 1'b1;
        repeat (3) tick();
        clear_sync();
        repeat (8) tick();
        idle_inputs();
        check_cleared("post_rsync_strobes");

        // Randomized operands and load-phase timing
        for (int i = 0; i < 40; i++) begin
            run_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3), 1'b1);
            clear_sync();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 The block SHALL have parameter WORD_LENGTH, default 4, operand width N in bits; product width 2N.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port data_in_a, input, N bits: unsigned multiplicand.
REQ-005 The block SHALL have port data_in_b, input, N bits: unsigned multiplier.
REQ-006 The block SHALL have port Start, input, 1 bit: begin operation and capture operands.
REQ-007 The block SHALL have port FinishLoad, input, 1 bit: leave LOAD and enter SHIFT.
REQ-008 The block SHALL have port FinishShift, input, 1 bit: leave SHIFT once all steps are done.
REQ-009 The block SHALL have port Finish, input, 1 bit: publish the result.
REQ-010 The block SHALL have port Reset_Sync, input, 1 bit: synchronous abort/clear back to IDLE.
REQ-011 The block SHALL have port data_out, output, 2N bits: registered unsigned product.
REQ-012 The block SHALL have port ready, output, 1 bit: result valid.
REQ-013 The block SHALL have port cout, output, 1 bit: carry out of the final add step.

Function
REQ-014 The block SHALL implement FSM states IDLE, LOAD, SHIFT, FINISH and DONE; all inputs are level-sampled each rising edge.
REQ-015 IDLE with Start=1 SHALL transition to LOAD, capturing A=data_in_a and Q=data_in_b and clearing accumulator ACC (N bits), step counter and carry; data_in_a/b SHALL be ignored at all other times.
REQ-016 LOAD with FinishLoad=1 SHALL transition to SHIFT; otherwise LOAD holds.
REQ-017 Each SHIFT cycle with counter<N SHALL perform one step: if Q[0]=1 then {c,ACC}=ACC+A (N+1 bits) else c=0; then {c,ACC,Q} is shifted right by 1 and the counter increments.
REQ-018 With counter=N the block SHALL perform no further steps and SHALL hold ACC, Q and the last c.
REQ-019 SHIFT SHALL transition to FINISH on FinishShift=1 only when counter=N; FinishShift asserted earlier SHALL be ignored.
REQ-020 FINISH with Finish=1 SHALL transition to DONE, loading data_out={ACC,Q} and cout=last c.
REQ-021 In DONE the block SHALL hold ready=1 and keep data_out and cout stable until Reset_Sync or reset.
REQ-022 Reset_Sync=1 in any state SHALL return the FSM to IDLE on the next edge and clear data_out, cout, ready, ACC and the counter.
REQ-023 Priority SHALL be reset > Reset_Sync > phase inputs; a phase input not matching the current state SHALL be ignored.
REQ-024 ready SHALL be 0 in every state except DONE; data_out and cout SHALL change only on DONE entry or on a clear.
REQ-025 Minimum latency from Start sampled to ready=1 SHALL be N+3 cycles (1 LOAD, N SHIFT, 1 FINISH, then DONE).
REQ-026 The product SHALL be exact unsigned a*b in 2N bits with no overflow.

Reset
REQ-027 reset=1 at a rising edge SHALL force state IDLE, data_out=0, ready=0, cout=0, and ACC, Q, A, the counter and c to 0, regardless of any other input.
REQ-028 Reset asserted mid-operation SHALL abort it; no partial result appears on data_out.

Verification
REQ-029 Bench SHALL cover: a=7, b=3, strobes Start, FinishLoad, FinishShift (after 4 SHIFT cycles), Finish -> data_out=0x15 (21), cout=0, ready=1.
REQ-030 Bench SHALL cover: a=15, b=15, full sequence -> data_out=0xE1 (225), cout=1, ready=1.
REQ-031 Bench SHALL cover: a=0, b=9 and a=9, b=0 -> data_out=0, cout=0, ready=1.
REQ-032 Bench SHALL cover: FinishShift asserted on the first SHIFT cycle only -> FSM stays in SHIFT; a later FinishShift with counter=4 moves it to FINISH.
REQ-033 Bench SHALL cover: Reset_Sync in DONE after 7*3 -> next cycle ready=0, data_out=0; a new Start with a=5, b=6 yields 30.
REQ-034 Bench SHALL cover: reset asserted in SHIFT -> IDLE, all outputs 0; Finish alone afterwards -> no change.
